hilo_muldiv_unit: RTL

//   Parametrised multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS core.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/hilo_muldiv_unit_div_step.sv | 26 ++
 rtl/hilo_muldiv_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide unit.
// Holds the FSM encoding, the op encoding and the magnitude helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic opDiv;
    logic resNeg;
    logic remNeg;
  } mode_t;

  function automatic logic [MAX_W-1:0] abs_w(
    input logic [MAX_W-1:0] x,
    input logic             sgn
  );
    return (sgn && x[MAX_W-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_step.sv
// One restoring-division iteration on {rem,quo}.
// Shifts left, trial-subtracts the divisor, sets the quotient bit.
module div_step import muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  acc,
  input  logic [WIDTH-1:0]  divisor,
  output logic [2*WIDTH:0]  accNxt
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {acc[2*WIDTH-1:0], 1'b0};
    diff    = {1'b0, shifted[2*WIDTH:WIDTH]}
            - {2'b00, divisor};
    if (diff[WIDTH+1]) begin
      accNxt = shifted;
    end else begin
      accNxt = {diff[WIDTH:0],
                shifted[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit feeding HI/LO.
// Stalls EX while busy; flush aborts without touching HI/LO.
module hilo_muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_div_i,
  input  logic             signed_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int AW = 2*WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state;
  state_e           stateNxt;
  mode_t            mode;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    accDiv;
  logic [AW-1:0]    accMul;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hiHold;
  logic [WIDTH-1:0] loHold;
  logic [WIDTH-1:0] hiRes;
  logic [WIDTH-1:0] loRes;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic [MAX_W-1:0] aAbs;
  logic [MAX_W-1:0] bAbs;
  logic [2*WIDTH-1:0] mulFull;
  logic [2*WIDTH-1:0] prodS;
  logic [WIDTH-1:0] quoS;
  logic [WIDTH-1:0] remS;
  logic             accept;
  logic             inRun;
  logic             inDone;
  logic             lastStep;
  logic             aNeg;
  logic             bNeg;

  assign aAbs = abs_w(MAX_W'($signed(a_i)), signed_i);
  assign bAbs = abs_w(MAX_W'($signed(b_i)), signed_i);
  assign aMag = aAbs[WIDTH-1:0];
  assign bMag = bAbs[WIDTH-1:0];
  assign aNeg = signed_i & a_i[WIDTH-1];
  assign bNeg = signed_i & b_i[WIDTH-1];

  assign accept   = (state == IDLE) & start_i & ~flush_i;
  assign inRun    = (state == RUN);
  assign inDone   = (state == DONE);
  assign lastStep = (cnt == CW'(1));

  assign mulFull = {{WIDTH{1'b0}}, aMag}
                 * {{WIDTH{1'b0}}, bMag};

  div_step #(.WIDTH(WIDTH)) uDivStep (
    .acc     (acc),
    .divisor (opnd),
    .accNxt  (accDiv)
  );

  // Shift-add: conditionally add multiplicand, then shift right.
  always_comb begin
    mulSum = acc[AW-1:WIDTH]
           + (acc[0] ? {1'b0, opnd} : '0);
    accMul = {1'b0, mulSum, acc[WIDTH-1:1]};
  end

  always_comb begin
    prodS = mode.resNeg ? -acc[2*WIDTH-1:0]
                        : acc[2*WIDTH-1:0];
    quoS  = mode.resNeg ? -acc[WIDTH-1:0]
                        : acc[WIDTH-1:0];
    remS  = mode.remNeg ? -acc[2*WIDTH-1:WIDTH]
                        : acc[2*WIDTH-1:WIDTH];
    if (mode.opDiv == OP_DIV) begin
      hiRes = remS;
      loRes = quoS;
    end else begin
      hiRes = prodS[2*WIDTH-1:WIDTH];
      loRes = prodS[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (op_div_i == OP_MUL && MUL_ITER == 0)
            stateNxt = DONE;
          else
            stateNxt = RUN;
        end
      end
      RUN: begin
        if (flush_i)       stateNxt = IDLE;
        else if (lastStep) stateNxt = DONE;
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state != IDLE) & ~rst;
    done_o  = inDone & ~rst;
    stall_o = accept | inRun;
    hi_o    = done_o ? hiRes : hiHold;
    lo_o    = done_o ? loRes : loHold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode   <= '0;
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      hiHold <= '0;
      loHold <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          mode.opDiv  <= op_div_i;
          mode.resNeg <= aNeg ^ bNeg;
          mode.remNeg <= aNeg;
          cnt         <= CW'(WIDTH);
          if (op_div_i == OP_DIV) begin
            acc  <= {{(WIDTH+1){1'b0}}, aMag};
            opnd <= bMag;
          end else if (MUL_ITER == 0) begin
            acc  <= {1'b0, mulFull};
            opnd <= aMag;
          end else begin
            acc  <= {{(WIDTH+1){1'b0}}, bMag};
            opnd <= aMag;
          end
        end
        inRun: begin
          if (!flush_i) begin
            cnt <= cnt - CW'(1);
            acc <= mode.opDiv ? accDiv : accMul;
          end
        end
        inDone: begin
          hiHold <= hiRes;
          loHold <= loRes;
        end
        default: ;
      endcase
    end
  end

endmodule
